// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB completer memory.
// Optional random wait-state extension is enabled with APB_SLV_RANDOM_WAIT_EN.
package apb_slv_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MEM_DEPTH  = 48;
    localparam int unsigned WAIT_W         = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Bit positions within the error-cause vector
    localparam int unsigned ERR_RANGE  = 0;
    localparam int unsigned ERR_ALIGN  = 1;
    localparam int unsigned ERR_RDSTRB = 2;
    localparam int unsigned ERR_NUM    = 3;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [WAIT_W-1:0] sat_wait_add(input logic [WAIT_W-1:0] a,
                                                      input logic [1:0]        b);
        logic [WAIT_W:0] sum;
        sum = {1'b0, a} + {{(WAIT_W-1){1'b0}}, b};
        return sum[WAIT_W] ? '1 : sum[WAIT_W-1:0];
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a requester and the apb_slave_mem completer.
// Built with or without APB_SLV_RANDOM_WAIT_EN; the bundle itself is unaffected.
interface apb_slave_mem_if
    import apb_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic                    PREADY;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_slv_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used for random wait-state padding.
// Instantiated only when APB_SLV_RANDOM_WAIT_EN is defined.
module apb_slv_lfsr
    import apb_slv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [1:0] o_rnd
);
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_rnd = r_lfsr[1:0];
endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed memory with byte strobes,
// programmable wait states and range/alignment/read-strobe error response.
// Define APB_SLV_RANDOM_WAIT_EN to pad each transfer with LFSR-derived waits.
module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH
)
(
    input  logic              PCLK,
    input  logic              PRESET_n,
    apb_slave_mem_if.slave    apb,
    input  logic [WAIT_W-1:0] wait_cfg
);
    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
    localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_W-1:0]     r_cnt;
    logic [WAIT_W-1:0]     w_cnt_nxt;
    logic [WAIT_W-1:0]     w_wait_eff;
    logic                  r_pready;
    logic                  w_pready_nxt;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pslverr;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_strb;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_latch;
    logic                  w_commit;
    logic                  w_rsp_load;
    logic                  w_rsp_clear;

    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_write;
    logic [STRB_W-1:0]     w_sel_strb;
    logic [ERR_NUM-1:0]    w_err_vec;
    logic                  w_err;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;

`ifdef APB_SLV_RANDOM_WAIT_EN
    logic [1:0] w_rnd;

    apb_slv_lfsr u_lfsr (
        .i_clk   (PCLK),
        .i_rst_n (PRESET_n),
        .o_rnd   (w_rnd)
    );

    assign w_wait_eff = sat_wait_add(wait_cfg, w_rnd);
`else
    assign w_wait_eff = wait_cfg;
`endif

    // A zero-wait setup loads the response from the live bus before it is latched
    assign w_sel_addr  = (r_state == IDLE) ? apb.PADDR  : r_addr;
    assign w_sel_write = (r_state == IDLE) ? apb.PWRITE : r_write;
    assign w_sel_strb  = (r_state == IDLE) ? apb.PSTRB  : r_strb;

    assign w_err_vec[ERR_RANGE]  = (32'(w_sel_addr) >= MEM_BYTES);
    assign w_err_vec[ERR_ALIGN]  = |w_sel_addr[1:0];
    assign w_err_vec[ERR_RDSTRB] = !w_sel_write && (|w_sel_strb);
    assign w_err                 = |w_err_vec;
    assign w_idx                 = w_sel_addr[ADDR_WIDTH-1:2];

    always_comb begin
        w_rd_data = '0;
        if (!w_err && !w_sel_write) begin
            w_rd_data = r_mem[w_idx];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pready_nxt = r_pready;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        w_rsp_load   = 1'b0;
        w_rsp_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    w_latch      = 1'b1;
                    w_state_nxt  = ACCESS;
                    w_cnt_nxt    = w_wait_eff;
                    w_pready_nxt = (w_wait_eff == '0);
                    w_rsp_load   = (w_wait_eff == '0);
                end
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    w_state_nxt  = IDLE;
                    w_pready_nxt = 1'b0;
                    w_rsp_clear  = 1'b1;
                end else if (apb.PENABLE) begin
                    if (r_pready) begin
                        w_commit     = r_write && !w_err;
                        w_state_nxt  = IDLE;
                        w_pready_nxt = 1'b0;
                        w_rsp_clear  = 1'b1;
                    end else begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                        w_pready_nxt = (r_cnt == WAIT_W'(1));
                        w_rsp_load   = (r_cnt == WAIT_W'(1));
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_pready <= w_pready_nxt;
            if (w_latch) begin
                r_addr  <= apb.PADDR;
                r_write <= apb.PWRITE;
                r_wdata <= apb.PWDATA;
                r_strb  <= apb.PSTRB;
            end
            if (w_rsp_load) begin
                r_prdata  <= w_rd_data;
                r_pslverr <= w_err;
            end else if (w_rsp_clear) begin
                r_prdata  <= '0;
                r_pslverr <= 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (r_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign apb.PREADY  = r_pready;
    assign apb.PRDATA  = r_prdata;
    assign apb.PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: the driver pushes model-derived responses,
// a negedge monitor pops and compares them on every completed transfer.
module tb_apb_slave_mem;
    localparam int DEPTH = 48;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic [3:0] wait_cfg;

    always #5 pclk = ~pclk;

    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .PCLK     (pclk),
        .PRESET_n (preset_n),
        .apb      (bus),
        .wait_cfg (wait_cfg)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          mon_waits = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic bit model_err(input bit wr, input logic [7:0] addr, input logic [3:0] strb);
        return (int'(addr) >= DEPTH * 4) || (addr % 4 != 0) || (!wr && strb != 0);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endfunction

    // Monitor: compares each completed transfer against the head of the queue
    always @(negedge pclk) begin
        if (!preset_n) begin
            mon_waits = 0;
        end else if (bus.PSEL && !bus.PENABLE) begin
            mon_waits = 0;
            check("setup_pready", bus.PREADY, 0);
            check("setup_prdata", bus.PRDATA, 0);
            check("setup_pslverr", bus.PSLVERR, 0);
        end else if (bus.PSEL && bus.PENABLE) begin
            if (!bus.PREADY) begin
                mon_waits++;
            end else begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("prdata", bus.PRDATA, e.rdata);
                    check("pslverr", bus.PSLVERR, e.slverr);
`ifdef APB_SLV_RANDOM_WAIT_EN
                    n_checks++;
                    if (mon_waits < e.waits || mon_waits > ((e.waits + 3 > 15) ? 15 : e.waits + 3)) begin
                        n_fail++;
                        $display("FAIL waits: got %0d, required %0d..+3", mon_waits, e.waits);
                    end
`else
                    check("waits", mon_waits, e.waits);
`endif
                end
                mon_waits = 0;
            end
        end else begin
            mon_waits = 0;
        end
    end

    task automatic drive_setup(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb, input logic [3:0] wc);
        wait_cfg    = wc;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wd;
        bus.PSTRB   = strb;
    endtask

    task automatic bus_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    // Full transfer; expected response comes from the array model
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [3:0] wc);
        exp_t e;
        bit   err;
        bit   done;
        int   guard;
        err      = model_err(wr, addr, strb);
        e.slverr = err;
        e.waits  = wc;
        e.rdata  = (!wr && !err) ? model_mem[addr / 4] : 32'h0;
        if (wr && !err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[addr / 4][8*b +: 8] = wd[8*b +: 8];
        end
        exp_q.push_back(e);
        drive_setup(wr, addr, wd, strb, wc);
        @(posedge pclk);
        #1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = 8'($urandom);
        bus.PWDATA  = $urandom;
        bus.PSTRB   = 4'($urandom);
        wait_cfg    = 4'($urandom);
        done  = 1'b0;
        guard = 0;
        while (!done && guard < 40) begin
            @(negedge pclk);
            if (bus.PREADY) begin
                @(posedge pclk);
                done = 1'b1;
            end
            guard++;
        end
        if (!done) begin
            check("completion_timeout", 0, 1);
            void'(exp_q.pop_back());
        end
        #1;
        bus_idle();
    endtask

    // Master drops PSEL during the wait phase; nothing may be written
    task automatic abort_xfer(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] wc);
        drive_setup(1'b1, addr, wd, 4'hF, wc);
        @(posedge pclk);
        #1;
        bus.PENABLE = 1'b1;
        @(posedge pclk);
        #1;
        bus_idle();
        @(posedge pclk);
        #1;
    endtask

    task automatic reset_now();
        preset_n = 1'b0;
        bus_idle();
        #1;
        check("rst_pready", bus.PREADY, 0);
        check("rst_prdata", bus.PRDATA, 0);
        check("rst_pslverr", bus.PSLVERR, 0);
        model_clear();
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  w;
        bit          wr;
        int          r;

        preset_n = 1'b0;
        wait_cfg = 4'h0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
        model_clear();
        repeat (3) @(posedge pclk);
        #1;
        check("reset_pready", bus.PREADY, 0);
        check("reset_prdata", bus.PRDATA, 0);
        check("reset_pslverr", bus.PSLVERR, 0);
        preset_n = 1'b1;

        xfer(1, 8'h04, 32'hDEADBEEF, 4'hF, 0);
        xfer(0, 8'h04, 32'h0, 4'h0, 0);
        xfer(0, 8'h00, 32'h0, 4'h0, 3);
        xfer(1, 8'h08, 32'h11223344, 4'hF, 1);
        xfer(1, 8'h08, 32'hAABBCCDD, 4'b0101, 2);
        xfer(0, 8'h08, 32'h0, 4'h0, 0);
        xfer(1, 8'hC0, 32'h55555555, 4'hF, 0);
        xfer(1, 8'h05, 32'h66666666, 4'hF, 1);
        xfer(0, 8'h04, 32'h0, 4'h0, 0);
        xfer(0, 8'h04, 32'h0, 4'h3, 0);
        xfer(1, 8'h04, 32'h77777777, 4'h0, 0);
        xfer(1, 8'hBC, 32'hFEEDFACE, 4'hF, 0);
        xfer(0, 8'hBC, 32'h0, 4'h0, 15);
        xfer(0, 8'h04, 32'h0, 4'h0, 1);

        // PSEL with PENABLE from IDLE is not a setup
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h04; bus.PWDATA = 32'hFFFFFFFF; bus.PSTRB = 4'hF; wait_cfg = 4'h0;
        repeat (3) begin
            @(negedge pclk);
            check("idle_enable_ignored", bus.PREADY, 0);
        end
        @(posedge pclk);
        #1;
        bus_idle();
        xfer(0, 8'h04, 32'h0, 4'h0, 0);

        abort_xfer(8'h10, 32'hCAFEF00D, 2);
        xfer(0, 8'h10, 32'h0, 4'h0, 0);
        xfer(1, 8'h14, 32'h0BADC0DE, 4'hF, 0);
        xfer(0, 8'h14, 32'h0, 4'h0, 2);

        // Reset during the wait phase of a write
        drive_setup(1'b1, 8'h0C, 32'h12345678, 4'hF, 4'd5);
        @(posedge pclk);
        #1;
        bus.PENABLE = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        reset_now();
        xfer(0, 8'h0C, 32'h0, 4'h0, 0);

        // Reset while a read response is being presented
        xfer(1, 8'h10, 32'h5A5AA5A5, 4'hF, 0);
        drive_setup(1'b0, 8'h10, 32'h0, 4'h0, 4'd1);
        @(posedge pclk);
        #1;
        bus.PENABLE = 1'b1;
        @(posedge pclk);
        #1;
        check("pre_reset_pready", bus.PREADY, 1);
        check("pre_reset_prdata", bus.PRDATA, 32'h5A5AA5A5);
        reset_now();
        xfer(0, 8'h10, 32'h0, 4'h0, 0);

        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = 8'($urandom_range(0, DEPTH - 1) * 4);
            else if (r < 85) a = 8'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else             a = 8'($urandom_range(192, 255));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (wr)                             s = 4'($urandom);
            else if ($urandom_range(0, 9) == 0) s = 4'($urandom_range(1, 15));
            else                                s = 4'h0;
            w = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) abort_xfer(a, d, 4'($urandom_range(2, 6)));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge pclk);
                #1;
            end
            xfer(wr, a, d, s, w);
        end

        repeat (3) @(posedge pclk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
